// File: rtl/dmi_access_sequencer.sv
// dmi_access_sequencer
// System-clock-domain bridge between the JTAG DTM request/response handshake
// and the debug-module register bus. One DMI request is in flight at a time.
// The request level is synchronised, the op is decoded, and a req/gnt/rvalid
// access runs with a per-phase timeout. {addr, data, status} goes back to the
// DTM before the busy level is released.

module dmi_access_sequencer #(
    parameter int DMI_ADDR_BITS  = 6,
    parameter int DMI_DATA_BITS  = 32,
    parameter int DMI_OP_BITS    = 2,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            dtm_req_valid,
    input  logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dtm_req_data,
    output logic                                            dm_is_busy,
    output logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dm_resp_data,
    output logic                                            reg_req,
    output logic                                            reg_we,
    output logic [DMI_ADDR_BITS-1:0]                        reg_addr,
    output logic [DMI_DATA_BITS-1:0]                        reg_wdata,
    input  logic                                            reg_gnt,
    input  logic                                            reg_rvalid,
    input  logic [DMI_DATA_BITS-1:0]                        reg_rdata
);

    localparam int REQ_W = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Last count value of a phase; the phase aborts when this count sees no progress.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [DMI_OP_BITS-1:0] OP_NOP      = DMI_OP_BITS'(0);
    localparam logic [DMI_OP_BITS-1:0] OP_READ     = DMI_OP_BITS'(1);
    localparam logic [DMI_OP_BITS-1:0] OP_WRITE    = DMI_OP_BITS'(2);
    localparam logic [DMI_OP_BITS-1:0] STATUS_OK   = DMI_OP_BITS'(0);
    localparam logic [DMI_OP_BITS-1:0] STATUS_FAIL = DMI_OP_BITS'(2);

    localparam logic [DMI_DATA_BITS-1:0] DATA_ZERO = {DMI_DATA_BITS{1'b0}};
    localparam logic [DMI_ADDR_BITS-1:0] ADDR_ZERO = {DMI_ADDR_BITS{1'b0}};
    localparam logic [REQ_W-1:0]         RESP_ZERO = {REQ_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_RESP     = 3'd2,
        ST_DONE     = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_e;

    logic [SYNC_STAGES-1:0]   vld_sync_q;
    logic                     vld_s;
    logic [DMI_ADDR_BITS-1:0] req_addr_s;
    logic [DMI_DATA_BITS-1:0] req_data_s;
    logic [DMI_OP_BITS-1:0]   req_op_s;

    state_e                   state_q;
    logic                     busy_q;
    logic                     req_q;
    logic                     we_q;
    logic [DMI_ADDR_BITS-1:0] addr_q;
    logic [DMI_DATA_BITS-1:0] wdata_q;
    logic [DMI_DATA_BITS-1:0] rdata_q;
    logic [DMI_OP_BITS-1:0]   status_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [REQ_W-1:0]         resp_q;

    assign vld_s      = vld_sync_q[SYNC_STAGES-1];
    assign req_op_s   = dtm_req_data[DMI_OP_BITS-1:0];
    assign req_data_s = dtm_req_data[DMI_OP_BITS+DMI_DATA_BITS-1:DMI_OP_BITS];
    assign req_addr_s = dtm_req_data[REQ_W-1:DMI_OP_BITS+DMI_DATA_BITS];

    assign dm_is_busy   = busy_q;
    assign dm_resp_data = resp_q;
    assign reg_req      = req_q;
    assign reg_we       = we_q;
    assign reg_addr     = addr_q;
    assign reg_wdata    = wdata_q;

    // Bring the TCK-domain request level into clk through a flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            vld_sync_q <= {vld_sync_q[SYNC_STAGES-2:0], dtm_req_valid};
        end
    end

    // Request sequencer: capture, bus access with timeout, response, handshake release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= ADDR_ZERO;
            wdata_q  <= DATA_ZERO;
            rdata_q  <= DATA_ZERO;
            status_q <= STATUS_OK;
            cnt_q    <= CNT_ZERO;
            resp_q   <= RESP_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (vld_s) begin
                        addr_q  <= req_addr_s;
                        wdata_q <= req_data_s;
                        we_q    <= (req_op_s == OP_WRITE);
                        rdata_q <= DATA_ZERO;
                        cnt_q   <= CNT_ZERO;
                        busy_q  <= 1'b1;
                        case (req_op_s)
                            OP_READ, OP_WRITE: begin
                                req_q   <= 1'b1;
                                state_q <= ST_REQ;
                            end
                            OP_NOP: begin
                                status_q <= STATUS_OK;
                                state_q  <= ST_DONE;
                            end
                            default: begin
                                status_q <= STATUS_FAIL;
                                state_q  <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_REQ: begin
                    if (reg_gnt) begin
                        req_q <= 1'b0;
                        cnt_q <= CNT_ZERO;
                        if (we_q) begin
                            // A write echoes its own data back to the DTM.
                            rdata_q  <= wdata_q;
                            status_q <= STATUS_OK;
                            state_q  <= ST_DONE;
                        end else begin
                            state_q <= ST_RESP;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        req_q    <= 1'b0;
                        rdata_q  <= DATA_ZERO;
                        status_q <= STATUS_FAIL;
                        state_q  <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_RESP: begin
                    if (reg_rvalid) begin
                        rdata_q  <= reg_rdata;
                        status_q <= STATUS_OK;
                        state_q  <= ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q  <= DATA_ZERO;
                        status_q <= STATUS_FAIL;
                        state_q  <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    // Response lands here, always at least one edge before busy can fall.
                    resp_q  <= {addr_q, rdata_q, status_q};
                    state_q <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    if (!vld_s) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_access_sequencer.sv
// Self-checking bench for dmi_access_sequencer: directed scenarios followed by
// randomised requests, each scored against a transaction-level model of the
// DMI rules (op decode, grant/rvalid deadlines, handshake timing).

module tb_dmi_access_sequencer;

    localparam int T  = 8;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dtm_req_valid;
    logic [39:0] dtm_req_data;
    logic        dm_is_busy;
    logic [39:0] dm_resp_data;
    logic        reg_req;
    logic        reg_we;
    logic [5:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_gnt;
    logic        reg_rvalid;
    logic [31:0] reg_rdata;

    int errors = 0;
    int checks = 0;

    // Bus agent / monitor state for the current transaction
    logic [1:0]  t_op;
    logic [5:0]  t_addr;
    logic [31:0] t_data;
    logic [31:0] t_rdata;
    int          t_gnt_dly;
    int          t_rv_dly;
    int          req_cnt;
    int          accesses;
    int          resp_cnt;
    int          bad_bus;
    int          idle_req;
    bit          granted;
    bit          rv_sent;
    bit          prev_req;
    logic [39:0] last_exp;

    always #5 clk = ~clk;

    dmi_access_sequencer #(
        .DMI_ADDR_BITS (6),
        .DMI_DATA_BITS (32),
        .DMI_OP_BITS   (2),
        .TIMEOUT_CYCLES(T),
        .SYNC_STAGES   (SS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dtm_req_valid(dtm_req_valid),
        .dtm_req_data (dtm_req_data),
        .dm_is_busy   (dm_is_busy),
        .dm_resp_data (dm_resp_data),
        .reg_req      (reg_req),
        .reg_we       (reg_we),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_gnt      (reg_gnt),
        .reg_rvalid   (reg_rvalid),
        .reg_rdata    (reg_rdata)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected DTM response from the DMI rules alone.
    function automatic logic [39:0] model(input logic [1:0] op, input logic [5:0] addr,
                                          input logic [31:0] data, input int gdly,
                                          input int rdly, input logic [31:0] rdata);
        if (op == 2'b00) return {addr, 32'h0, 2'b00};
        if (op == 2'b11) return {addr, 32'h0, 2'b10};
        if (op == 2'b10) return (gdly < T) ? {addr, data, 2'b00} : {addr, 32'h0, 2'b10};
        return (gdly < T && rdly < T) ? {addr, rdata, 2'b00} : {addr, 32'h0, 2'b10};
    endfunction

    task automatic clear_txn_state();
        req_cnt  = 0;
        accesses = 0;
        resp_cnt = 0;
        bad_bus  = 0;
        idle_req = 0;
        granted  = 1'b0;
        rv_sent  = 1'b0;
    endtask

    // One clock: observe at the falling edge, then drive the bus responder.
    task automatic step();
        @(negedge clk);
        if (reg_req && !dm_is_busy) idle_req++;
        if (reg_req) begin
            if (!prev_req) accesses++;
            if (reg_we !== (t_op == 2'b10) || reg_addr !== t_addr || reg_wdata !== t_data)
                bad_bus++;
        end
        prev_req = reg_req;

        reg_gnt    = 1'b0;
        reg_rvalid = 1'b0;
        reg_rdata  = $urandom;
        if (granted && t_op == 2'b01 && !rv_sent) begin
            if (resp_cnt == t_rv_dly) begin
                reg_rvalid = 1'b1;
                reg_rdata  = t_rdata;
                rv_sent    = 1'b1;
            end
            resp_cnt++;
        end else if ($urandom_range(0, 5) == 0) begin
            reg_rvalid = 1'b1;   // spurious, nothing is waiting for read data
        end
        if (reg_req) begin
            if (req_cnt == t_gnt_dly) begin
                reg_gnt = 1'b1;
                granted = 1'b1;
            end
            req_cnt++;
        end else if ($urandom_range(0, 5) == 0) begin
            reg_gnt = 1'b1;      // spurious, no request outstanding
        end
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [5:0] addr, input logic [31:0] data,
                           input int gdly, input int rdly, input logic [31:0] rdata, input int hold);
        logic [39:0] exp;
        int n;
        int drops;
        int exp_acc;
        int exp_req_hi;
        exp        = model(op, addr, data, gdly, rdly, rdata);
        exp_acc    = (op == 2'b01 || op == 2'b10) ? 1 : 0;
        exp_req_hi = (exp_acc == 0) ? 0 : ((gdly < T) ? gdly + 1 : T);
        t_op = op; t_addr = addr; t_data = data; t_rdata = rdata;
        t_gnt_dly = gdly; t_rv_dly = rdly;
        clear_txn_state();

        check("resp_stable_idle", dm_resp_data, last_exp);
        check("busy_idle", dm_is_busy, 1'b0);
        dtm_req_valid = 1'b1;
        dtm_req_data  = {addr, data, op};
        step();
        step();
        check("busy_lat2", dm_is_busy, 1'b0);
        step();
        check("busy_lat3", dm_is_busy, 1'b1);

        drops = 0;
        for (int i = 0; i < hold; i++) begin
            step();
            if (!dm_is_busy) drops++;
        end
        if (hold > 0) begin
            check("busy_held", drops, 0);
            check("resp_before_fall", dm_resp_data, exp);
        end

        dtm_req_valid = 1'b0;
        n = 0;
        while (dm_is_busy && n < 40) begin
            step();
            n++;
        end
        check("busy_fell", dm_is_busy, 1'b0);
        if (hold >= 25) check("release_latency", (n <= SS + 1), 1'b1);
        check("resp_final", dm_resp_data, exp);
        check("accesses", accesses, exp_acc);
        check("req_cycles", req_cnt, exp_req_hi);
        check("bus_fields", bad_bus, 0);
        check("req_without_busy", idle_req, 0);
        last_exp     = exp;
        dtm_req_data = {$urandom, $urandom};
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        dtm_req_valid = 1'b0;
        dtm_req_data  = 40'h0;
        reg_gnt       = 1'b0;
        reg_rvalid    = 1'b0;
        reg_rdata     = 32'h0;
        t_op = 2'b00; t_addr = 6'h0; t_data = 32'h0; t_rdata = 32'h0;
        t_gnt_dly = 0; t_rv_dly = 0;
        prev_req = 1'b0;
        last_exp = 40'h0;
        clear_txn_state();

        repeat (3) @(negedge clk);
        check("rst_busy", dm_is_busy, 1'b0);
        check("rst_resp", dm_resp_data, 40'h0);
        check("rst_bus", {reg_req, reg_we, reg_addr, reg_wdata}, 40'h0);
        rst_n = 1'b1;
        step();

        // Directed scenarios
        run_txn(2'b10, 6'h10, 32'hDEADBEEF, 2, 0, 32'h0, 25);          // write
        run_txn(2'b01, 6'h11, 32'h0, 0, 3, 32'h12345678, 25);          // read
        run_txn(2'b00, 6'h05, 32'hAAAA5555, 0, 0, 32'h0, 25);          // nop
        run_txn(2'b11, 6'h3F, 32'h5555AAAA, 0, 0, 32'h0, 25);          // reserved
        run_txn(2'b10, 6'h20, 32'hCAFEF00D, 100, 0, 32'h0, 25);        // grant timeout
        run_txn(2'b10, 6'h2A, 32'h0BADF00D, 1, 0, 32'h0, 25);          // recovers
        run_txn(2'b10, 6'h07, 32'h13579BDF, T - 1, 0, 32'h0, 25);      // last-cycle grant
        run_txn(2'b01, 6'h08, 32'h0, 1, 20, 32'hFFFF0000, 25);         // rvalid timeout
        run_txn(2'b01, 6'h09, 32'h0, 0, T - 1, 32'hA5A5A5A5, 25);      // last-cycle rvalid
        run_txn(2'b01, 6'h0C, 32'h0, 1, 2, 32'h87654321, 50);          // long hold
        run_txn(2'b01, 6'h0D, 32'h0, 2, 3, 32'h0F0F0F0F, 0);           // driver abort

        // Reset while the read is waiting for rvalid
        t_op = 2'b01; t_addr = 6'h22; t_data = 32'h0; t_rdata = 32'h11223344;
        t_gnt_dly = 1; t_rv_dly = 6;
        clear_txn_state();
        dtm_req_valid = 1'b1;
        dtm_req_data  = {6'h22, 32'h0, 2'b01};
        n = 0;
        while (!(granted && resp_cnt >= 2) && n < 50) begin
            step();
            n++;
        end
        check("reached_resp", (granted && resp_cnt >= 2), 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_req", reg_req, 1'b0);
        check("midrst_busy", dm_is_busy, 1'b0);
        check("midrst_resp", dm_resp_data, 40'h0);
        check("midrst_bus", {reg_we, reg_addr, reg_wdata}, 39'h0);
        dtm_req_valid = 1'b0;
        granted       = 1'b0;
        step();
        step();
        rst_n    = 1'b1;
        last_exp = 40'h0;
        step();
        run_txn(2'b01, 6'h23, 32'h0, 0, 1, 32'h55667788, 25);

        // Randomised back-to-back traffic
        for (int k = 0; k < 40; k++) begin
            run_txn(2'($urandom_range(0, 3)), 6'($urandom), $urandom,
                    int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), $urandom, 25);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmi_access_sequencer.md
Name: dmi_access_sequencer

Overview:
- System-clock-domain controller between the JTAG DTM request/response interface and the debug-module register bus.
- Accepts one DMI request at a time over an asynchronous four-phase level handshake (dtm_req_valid / dm_is_busy).
- Decodes the DMI op, runs the register read or write with req/gnt/rvalid sequencing and a timeout, and returns {addr, data, op} to the DTM.
- Sits beside the debug module and owns all DM register accesses originating from JTAG.

Parameters:
- DMI_ADDR_BITS, 6, DMI address width.
- DMI_DATA_BITS, 32, DMI data width.
- DMI_OP_BITS, 2, DMI op width.
- TIMEOUT_CYCLES, 256, clk cycles allowed per bus phase (gnt wait, rvalid wait) before abort; must be >= 2.
- SYNC_STAGES, 2, synchroniser depth for dtm_req_valid; must be >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- dtm_req_valid  in  1  request level from TCK domain (asynchronous)
- dtm_req_data  in  40  {addr[39:34], data[33:2], op[1:0]}; stable while dtm_req_valid=1
- dm_is_busy  out  1  registered; high from request capture until the handshake is released
- dm_resp_data  out  40  {addr, rdata, status}; registered, changes only on completion
- reg_req  out  1  bus request
- reg_we  out  1  1=write, 0=read; valid with reg_req
- reg_addr  out  6  register address; valid with reg_req
- reg_wdata  out  32  write data; valid with reg_req
- reg_gnt  in  1  bus accepts the request in the cycle reg_req&reg_gnt
- reg_rvalid  in  1  read data valid; ignored for writes
- reg_rdata  in  32  read data, sampled when reg_rvalid=1

Behaviour:
- Reset: all outputs 0, state IDLE, synchroniser cleared, timeout counter 0.
- Synchronisation: dtm_req_valid passes through SYNC_STAGES flops to give vld_s. dtm_req_data is sampled only on the cycle a request is accepted.
- IDLE:
  - On vld_s=1: latch addr/data/op, set dm_is_busy=1 on the next edge. With SYNC_STAGES=2, busy rises 3 edges after the valid input edge.
  - op=01 (read) or 10 (write): go to REQ.
  - op=00 (nop): go to DONE with status 00 and rdata 0.
  - op=11 (reserved): go to DONE with status 10.
- REQ:
  - reg_req=1 with reg_we/addr/wdata held.
  - reg_gnt=1: drop reg_req next cycle. A write goes to DONE with status 00; a read goes to RESP.
  - Counter reaches TIMEOUT_CYCLES with no gnt: drop reg_req, go to DONE with status 10 and rdata 0.
- RESP:
  - Wait for reg_rvalid, which may arrive no earlier than the cycle after gnt. Capture reg_rdata, status 00, go to DONE.
  - Timeout: status 10, rdata 0.
  - The counter restarts at 0 on entry to each of REQ and RESP.
- DONE (one cycle):
  - Write dm_resp_data = {latched addr, rdata-or-0, status}. A write returns its own wdata in the data field.
  - Go to WAIT_REL.
- WAIT_REL:
  - Hold dm_is_busy=1 until vld_s=0, then clear dm_is_busy and go to IDLE.
  - A new request is not accepted until busy has been low for at least one cycle.
- Ordering guarantee: dm_resp_data is updated strictly before dm_is_busy falls and is stable while busy is low.
- Spurious inputs: reg_gnt/reg_rvalid outside REQ/RESP are ignored. A second rvalid after completion is ignored.
- vld_s drops while in REQ/RESP (driver abort): the bus transaction still completes. The response is still written, then busy clears in WAIT_REL.
- Reset mid-transaction: reg_req drops immediately (asynchronous), busy clears, state returns to IDLE, and dm_resp_data returns to 0. No partial response is produced.
- Never more than one outstanding bus request; reg_req never asserts while dm_is_busy=0.

Test Plan:
- Write: req {addr=0x10, data=0xDEADBEEF, op=10}, gnt after 2 cycles -> one reg_req pulse with reg_we=1, addr 0x10, wdata 0xDEADBEEF. Then dm_resp_data={0x10,0xDEADBEEF,00}, and busy falls after valid is released.
- Read: op=01, addr 0x11, gnt immediately, rvalid after 3 cycles with 0x12345678 -> dm_resp_data={0x11,0x12345678,00} before busy falls.
- Nop and reserved ops: op=00 -> no reg_req, response {addr,0,00}. op=11 -> no reg_req, response {addr,0,10}.
- Timeout: TIMEOUT_CYCLES=8, reg_gnt held 0 -> reg_req drops after 8 cycles, response status 10. The next request completes normally.
- Handshake: hold dtm_req_valid high for 50 cycles after completion -> busy stays 1 with exactly one bus access. Release valid -> busy falls within SYNC_STAGES+1 cycles. Back-to-back requests produce no duplicate access.
- Reset: assert rst_n=0 during RESP -> all outputs 0 at once. After release, a read completes with a correct response.
